dma_ctrl: RTL and testbench
===========================

# dma_ctrl

Single-channel word DMA controller for the RV32I MCU. It is a bus slave at 0x4000_05xx, configured by the core through SRC/DST/LEN/CTRL/STATUS registers. It is also a second bus master that requests the shared data bus (address, write data, write enable, BHW) from the bus arbiter. Once granted, it sequences read-then-write word copies, for example RAM to GPO/FND or GPI/DHT11 to RAM.

## Interface
- `ADDR_W`, default 32: master address width.
- `LEN_W`, default 16: transfer length counter width, in words.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cs`  in  1  slave select from the address decoder
- `wr`  in  1  slave write enable
- `addr`  in  32  slave address; only [4:2] are decoded
- `wdata`  in  32  slave write data
- `rdata`  out  32  slave read data, combinational
- `busReq`  out  1  master bus request
- `busGnt`  in  1  grant from the arbiter
- `mAddr`  out  32  master address
- `mWrData`  out  32  master write data
- `mWe`  out  1  master write enable
- `mBHW`  out  2  access size; always BHW_WORD
- `mRdData`  in  32  master read data, combinational, valid in the same cycle
- `irq`  out  1  done interrupt

## Operation
- **Register map** (offset: register):
  - 0x00 SRC
  - 0x04 DST
  - 0x08 LEN: [LEN_W-1:0], in words
  - 0x0C CTRL:
    - b0 start: write-1, self-clearing, reads 0
    - b1 srcInc
    - b2 dstInc
    - b3 ien
    - b4 abort: write-1, self-clearing
  - 0x10 STATUS:
    - b0 busy
    - b1 done: sticky, write-1-to-clear
    - b2 aborted: sticky, write-1-to-clear
  - Other offsets read 0 and ignore writes.
- **Writes while busy:** writes to SRC, DST, LEN and CTRL b1–b3 are ignored. A start while busy is ignored. Abort is honoured.
- **States:** IDLE, REQ, READ, WRITE.
- **IDLE → REQ:** on start with LEN≠0. Working copies are loaded: curSrc, curDst, cnt=LEN.
- **Start with LEN=0:** done sets next cycle, no bus activity, and the FSM stays in IDLE.
- **REQ:** busReq=1. Move to READ when busGnt=1.
- **READ:** mAddr=curSrc, mWe=0.
  - If busGnt=1: latch mRdData into buf and go to WRITE.
  - Otherwise hold in READ.
- **WRITE:** mAddr=curDst, mWrData=buf, mWe=1.
  - If busGnt=1, all of these happen in one edge:
    - cnt−1
    - curSrc +4 if srcInc
    - curDst +4 if dstInc
  - Next state:
    - IDLE if cnt==1, which also sets done.
    - READ otherwise.
  - If busGnt=0: hold in WRITE.
- **Address wrap:** addresses wrap modulo 2^32. No alignment check; low two bits are passed through unchanged.
- **Master outputs:** busReq=1 in REQ, READ and WRITE. mWe=0 outside WRITE. mAddr and mWrData are 0 in IDLE and REQ.
- **Abort:**
  - From any non-IDLE state, the FSM returns to IDLE next edge and sets aborted.
  - done is not set.
  - A WRITE in progress on the abort cycle is suppressed: mWe is forced to 0 that cycle.
- **Interrupt:** irq = done & ien, combinational, held until done is cleared.
- **Simultaneous events:**
  - done set and a W1C in the same cycle: set wins.
  - start and abort in the same write: abort wins, nothing starts.

## Timing
- **Reset:** all registers, buf, cnt and state go to 0/IDLE. All outputs are 0: rdata reflects the zeroed registers, busReq=0, mWe=0, irq=0.
- **Reset mid-transfer:** takes effect immediately and asynchronously. busReq and mWe drop in the same cycle.
- **Start:** start written at edge N → REQ, busReq=1 after edge N.
- **Steady grant:** 1 REQ cycle plus 2 cycles per word.
  - done visible after edge N+1+2·LEN.
  - busy clears at the same edge.
- **Grant deasserted:** the FSM freezes in its current state with outputs stable. No words are skipped or duplicated.
- **Register reads:** combinational from the current register state. STATUS.busy equals state≠IDLE.

## Structure
- Shared package `dma_pkg`:
  - Register offsets: DMA_SRC, DMA_DST, DMA_LEN, DMA_CTRL, DMA_STATUS.
  - CTRL/STATUS bit indices.
  - State encoding.
  - BHW_WORD constant.
  - DMA base address 0x4000_05xx, for the decoder and mux update.
- Sub-module `dma_regs`: slave register file, start/abort pulse generation, W1C logic.
- The top holds the FSM, counters and master datapath.

## Test plan
- SRC=0x200, DST=0x4000_0000, LEN=3, srcInc=1, dstInc=0, grant tied 1, RAM holding 0x11/0x22/0x33:
  - 3 writes to 0x4000_0000 with data 0x11, 0x22, 0x33.
  - done after 7 cycles.
  - irq=1 when ien=1.
- Same copy with busGnt toggled 0/1 every other cycle → identical write sequence. mAddr/mWrData are stable while busGnt=0.
- LEN=0 start → done=1 next cycle; busReq never asserts.
- Abort written during the second WRITE of a LEN=4 job → that write suppressed (mWe=0), aborted=1, done=0, busReq=0 next cycle.
- Reset asserted mid-READ → busReq=0 immediately; all registers read 0 after reset release.
- Writes to SRC while busy → ignored. Start while busy → ignored. W1C on done → done=0, irq=0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel word DMA: register map, bit fields,
// FSM encoding and the peripheral base address used by the decoder and read mux.
package dma_pkg;

   localparam logic [31:0] DMA_BASE = 32'h4000_0500;

   // Register word indices, i.e. slave addr[4:2]
   localparam logic [2:0] DMA_SRC    = 3'd0;
   localparam logic [2:0] DMA_DST    = 3'd1;
   localparam logic [2:0] DMA_LEN    = 3'd2;
   localparam logic [2:0] DMA_CTRL   = 3'd3;
   localparam logic [2:0] DMA_STATUS = 3'd4;

   localparam int CTRL_START   = 0;
   localparam int CTRL_SRC_INC = 1;
   localparam int CTRL_DST_INC = 2;
   localparam int CTRL_IEN     = 3;
   localparam int CTRL_ABORT   = 4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

   localparam logic [1:0] BHW_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_READ  = 2'd2,
      ST_WRITE = 2'd3
   } dma_state_t;

   function automatic logic is_dma_addr(input logic [31:0] a);
      return a[31:8] == DMA_BASE[31:8];
   endfunction

endpackage

// File: rtl/dma_regs.sv
// DMA slave register file: SRC/DST/LEN/CTRL config, start/abort strobes, sticky
// W1C status. Reads are combinational; config writes are locked out while busy.
module dma_regs
   import dma_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cs,
   input  logic              i_wr,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   input  logic              i_busy,
   input  logic              i_done_set,
   input  logic              i_abort_set,
   output logic [31:0]       o_rdata,
   output logic [ADDR_W-1:0] o_src,
   output logic [ADDR_W-1:0] o_dst,
   output logic [LEN_W-1:0]  o_len,
   output logic              o_src_inc,
   output logic              o_dst_inc,
   output logic              o_ien,
   output logic              o_start,
   output logic              o_abort,
   output logic              o_done,
   output logic              o_aborted
);

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_len;
   logic              r_src_inc;
   logic              r_dst_inc;
   logic              r_ien;
   logic              r_done;
   logic              r_aborted;

   logic [2:0] w_sel;
   logic       w_wr;
   logic       w_cfg_wr;
   logic       w_ctrl_wr;
   logic       w_stat_wr;
   logic       w_unused_addr;

   assign w_sel         = i_addr[4:2];
   assign w_wr          = i_cs & i_wr;
   assign w_cfg_wr      = w_wr & ~i_busy;
   assign w_ctrl_wr     = w_wr & (w_sel == DMA_CTRL);
   assign w_stat_wr     = w_wr & (w_sel == DMA_STATUS);
   assign w_unused_addr = &{1'b0, i_addr[31:5], i_addr[1:0]};

   // Abort beats a start carried in the same write
   assign o_abort = w_ctrl_wr & i_wdata[CTRL_ABORT];
   assign o_start = w_ctrl_wr & i_wdata[CTRL_START] & ~i_wdata[CTRL_ABORT] & ~i_busy;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_src_inc <= 1'b0;
         r_dst_inc <= 1'b0;
         r_ien     <= 1'b0;
      end else if (w_cfg_wr) begin
         case (w_sel)
            DMA_SRC: r_src <= i_wdata[ADDR_W-1:0];
            DMA_DST: r_dst <= i_wdata[ADDR_W-1:0];
            DMA_LEN: r_len <= i_wdata[LEN_W-1:0];
            DMA_CTRL: begin
               r_src_inc <= i_wdata[CTRL_SRC_INC];
               r_dst_inc <= i_wdata[CTRL_DST_INC];
               r_ien     <= i_wdata[CTRL_IEN];
            end
            default: ;
         endcase
      end
   end

   // A set in the same cycle as the W1C wins
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_done    <= i_done_set  | (r_done    & ~(w_stat_wr & i_wdata[STAT_DONE]));
         r_aborted <= i_abort_set | (r_aborted & ~(w_stat_wr & i_wdata[STAT_ABORTED]));
      end
   end

   always_comb begin
      o_rdata = '0;
      case (w_sel)
         DMA_SRC:  o_rdata = 32'(r_src);
         DMA_DST:  o_rdata = 32'(r_dst);
         DMA_LEN:  o_rdata = 32'(r_len);
         DMA_CTRL: begin
            o_rdata[CTRL_SRC_INC] = r_src_inc;
            o_rdata[CTRL_DST_INC] = r_dst_inc;
            o_rdata[CTRL_IEN]     = r_ien;
         end
         DMA_STATUS: begin
            o_rdata[STAT_BUSY]    = i_busy;
            o_rdata[STAT_DONE]    = r_done;
            o_rdata[STAT_ABORTED] = r_aborted;
         end
         default: o_rdata = '0;
      endcase
   end

   assign o_src     = r_src;
   assign o_dst     = r_dst;
   assign o_len     = r_len;
   assign o_src_inc = r_src_inc;
   assign o_dst_inc = r_dst_inc;
   assign o_ien     = r_ien;
   assign o_done    = r_done;
   assign o_aborted = r_aborted;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel word DMA: bus master copying LEN words read-then-write, 1 REQ cycle
// plus 2 cycles per word; the FSM freezes whenever the arbiter withholds grant.
module dma_ctrl
   import dma_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cs,
   input  logic              i_wr,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic              o_busReq,
   input  logic              i_busGnt,
   output logic [ADDR_W-1:0] o_mAddr,
   output logic [31:0]       o_mWrData,
   output logic              o_mWe,
   output logic [1:0]        o_mBHW,
   input  logic [31:0]       i_mRdData,
   output logic              o_irq
);

   dma_state_t r_state;
   dma_state_t w_next;

   logic [ADDR_W-1:0] r_cur_src;
   logic [ADDR_W-1:0] r_cur_dst;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       r_buf;

   logic [ADDR_W-1:0] w_src;
   logic [ADDR_W-1:0] w_dst;
   logic [LEN_W-1:0]  w_len;
   logic              w_src_inc;
   logic              w_dst_inc;
   logic              w_ien;
   logic              w_start;
   logic              w_abort;
   logic              w_done;
   logic              w_aborted;
   logic              w_busy;
   logic              w_abort_set;
   logic              w_done_set;
   logic              w_load;
   logic              w_latch;
   logic              w_step;

   assign w_busy      = (r_state != ST_IDLE);
   assign w_abort_set = w_abort & w_busy;

   dma_regs #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_regs (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_cs        (i_cs),
      .i_wr        (i_wr),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_busy      (w_busy),
      .i_done_set  (w_done_set),
      .i_abort_set (w_abort_set),
      .o_rdata     (o_rdata),
      .o_src       (w_src),
      .o_dst       (w_dst),
      .o_len       (w_len),
      .o_src_inc   (w_src_inc),
      .o_dst_inc   (w_dst_inc),
      .o_ien       (w_ien),
      .o_start     (w_start),
      .o_abort     (w_abort),
      .o_done      (w_done),
      .o_aborted   (w_aborted)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      o_busReq   = 1'b0;
      o_mAddr    = '0;
      o_mWrData  = '0;
      o_mWe      = 1'b0;
      w_load     = 1'b0;
      w_latch    = 1'b0;
      w_step     = 1'b0;
      w_done_set = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               if (w_len != '0) begin
                  w_next = ST_REQ;
                  w_load = 1'b1;
               end else begin
                  w_done_set = 1'b1;
               end
            end
         end
         ST_REQ: begin
            o_busReq = 1'b1;
            if (w_abort) begin
               w_next = ST_IDLE;
            end else if (i_busGnt) begin
               w_next = ST_READ;
            end
         end
         ST_READ: begin
            o_busReq = 1'b1;
            o_mAddr  = r_cur_src;
            if (w_abort) begin
               w_next = ST_IDLE;
            end else if (i_busGnt) begin
               w_latch = 1'b1;
               w_next  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_busReq  = 1'b1;
            o_mAddr   = r_cur_dst;
            o_mWrData = r_buf;
            // The word in flight on an abort cycle must not reach the target
            o_mWe     = ~w_abort;
            if (w_abort) begin
               w_next = ST_IDLE;
            end else if (i_busGnt) begin
               w_step = 1'b1;
               if (r_cnt == LEN_W'(1)) begin
                  w_next     = ST_IDLE;
                  w_done_set = 1'b1;
               end else begin
                  w_next = ST_READ;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cur_src <= '0;
         r_cur_dst <= '0;
         r_cnt     <= '0;
         r_buf     <= '0;
      end else begin
         if (w_load) begin
            r_cur_src <= w_src;
            r_cur_dst <= w_dst;
            r_cnt     <= w_len;
         end
         if (w_latch) begin
            r_buf <= i_mRdData;
         end
         if (w_step) begin
            r_cnt <= r_cnt - LEN_W'(1);
            if (w_src_inc) begin
               r_cur_src <= r_cur_src + ADDR_W'(4);
            end
            if (w_dst_inc) begin
               r_cur_dst <= r_cur_dst + ADDR_W'(4);
            end
         end
      end
   end

   assign o_mBHW = BHW_WORD;
   assign o_irq  = w_done & w_ien;

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: expected bus writes are queued as jobs are set up
// and popped when the DUT commits a granted write.
module tb_dma_ctrl;
   import dma_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        bus_req;
   logic        bus_gnt = 1'b1;
   logic [31:0] m_addr;
   logic [31:0] m_wr_data;
   logic [31:0] m_rd_data;
   logic        m_we;
   logic [1:0]  m_bhw;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];
   logic        chk_stable = 1'b0;
   logic        prev_low = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdat = '0;

   always #5 clk = ~clk;

   dma_ctrl #(.ADDR_W(32), .LEN_W(16)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_cs      (cs),
      .i_wr      (wr),
      .i_addr    (addr),
      .i_wdata   (wdata),
      .o_rdata   (rdata),
      .o_busReq  (bus_req),
      .i_busGnt  (bus_gnt),
      .o_mAddr   (m_addr),
      .o_mWrData (m_wr_data),
      .o_mWe     (m_we),
      .o_mBHW    (m_bhw),
      .i_mRdData (m_rd_data),
      .o_irq     (irq)
   );

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      case (a)
         32'h0000_0200: return 32'h11;
         32'h0000_0204: return 32'h22;
         32'h0000_0208: return 32'h33;
         32'h0000_020C: return 32'h44;
         default:       return 32'hBAD0_0000 ^ a;
      endcase
   endfunction

   always_comb m_rd_data = ram_rd(m_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && m_we && bus_gnt) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", m_addr, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", m_addr, e[63:32]);
            check("wr_data", m_wr_data, e[31:0]);
         end
      end
      if (chk_stable && prev_low && bus_req) begin
         check("stable_addr", m_addr, prev_addr);
         check("stable_wdat", m_wr_data, prev_wdat);
      end
      prev_low  = !bus_gnt;
      prev_addr = m_addr;
      prev_wdat = m_wr_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [2:0] off, input logic [31:0] d);
      cs    = 1'b1;
      wr    = 1'b1;
      addr  = DMA_BASE | {27'd0, off, 2'b00};
      wdata = d;
      tick();
      cs    = 1'b0;
      wr    = 1'b0;
      wdata = '0;
   endtask

   task automatic reg_rd(input logic [2:0] off, output logic [31:0] d);
      cs   = 1'b1;
      wr   = 1'b0;
      addr = DMA_BASE | {27'd0, off, 2'b00};
      #1;
      d  = rdata;
      cs = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] v;
      reg_rd(off, v);
      check(tag, v, exp);
   endtask

   task automatic wait_done(input int max_cyc);
      logic [31:0] s;
      bit ok;
      ok = 1'b0;
      s  = '0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         reg_rd(DMA_STATUS, s);
         if (s[STAT_DONE]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("done_timeout", s, 32'h2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      bit seen;

      // Reset state
      #2;
      check("rst_busReq", 32'(bus_req), 32'h0);
      check("rst_mWe", 32'(m_we), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_mBHW", 32'(m_bhw), 32'(BHW_WORD));
      for (int r = 0; r < 5; r++) rd_chk("rst_reg", 3'(r), 32'h0);
      rst = 1'b0;
      tick();

      // Basic copy, steady grant, exact timing
      reg_wr(DMA_SRC, 32'h0000_0200);
      reg_wr(DMA_DST, 32'h4000_0000);
      reg_wr(DMA_LEN, 32'd3);
      push(32'h4000_0000, 32'h11);
      push(32'h4000_0000, 32'h22);
      push(32'h4000_0000, 32'h33);
      reg_wr(DMA_CTRL, 32'h0B);
      check("t1_busReq", 32'(bus_req), 32'h1);
      for (int k = 1; k <= 6; k++) tick();
      rd_chk("t1_busy_pre", DMA_STATUS, 32'h1);
      tick();
      rd_chk("t1_done", DMA_STATUS, 32'h2);
      check("t1_irq", 32'(irq), 32'h1);
      check("t1_q_empty", 32'(exp_q.size()), 32'h0);
      rd_chk("t1_ctrl", DMA_CTRL, 32'h0A);
      reg_wr(DMA_STATUS, 32'h2);
      check("t1_irq_clr", 32'(irq), 32'h0);
      rd_chk("t1_stat_clr", DMA_STATUS, 32'h0);

      // Same copy with grant toggling every cycle
      push(32'h4000_0000, 32'h11);
      push(32'h4000_0000, 32'h22);
      push(32'h4000_0000, 32'h33);
      chk_stable = 1'b1;
      bus_gnt    = 1'b0;
      reg_wr(DMA_CTRL, 32'h03);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         bus_gnt = ~bus_gnt;
         reg_rd(DMA_STATUS, v);
         if (v[STAT_DONE]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("t2_done_timeout", v, 32'h2);
      tick();
      bus_gnt    = 1'b1;
      chk_stable = 1'b0;
      check("t2_q_empty", 32'(exp_q.size()), 32'h0);
      rd_chk("t2_status", DMA_STATUS, 32'h2);
      check("t2_irq_off", 32'(irq), 32'h0);
      reg_wr(DMA_STATUS, 32'h2);

      // Zero-length start: done next cycle, no bus activity
      reg_wr(DMA_LEN, 32'd0);
      reg_wr(DMA_CTRL, 32'h01);
      rd_chk("t3_done", DMA_STATUS, 32'h2);
      for (int i = 0; i < 5; i++) begin
         check("t3_no_req", 32'(bus_req), 32'h0);
         tick();
      end
      reg_wr(DMA_STATUS, 32'h2);

      // Abort during second WRITE of a LEN=4 job
      reg_wr(DMA_SRC, 32'h0000_0200);
      reg_wr(DMA_DST, 32'h0000_0300);
      reg_wr(DMA_LEN, 32'd4);
      push(32'h0000_0300, 32'h11);
      reg_wr(DMA_CTRL, 32'h07);
      for (int k = 0; k < 4; k++) tick();
      check("t4_we_pre", 32'(m_we), 32'h1);
      check("t4_addr_pre", m_addr, 32'h0000_0304);
      cs    = 1'b1;
      wr    = 1'b1;
      addr  = DMA_BASE | {27'd0, DMA_CTRL, 2'b00};
      wdata = 32'h10;
      #1;
      check("t4_we_supp", 32'(m_we), 32'h0);
      tick();
      cs    = 1'b0;
      wr    = 1'b0;
      wdata = '0;
      check("t4_busReq", 32'(bus_req), 32'h0);
      rd_chk("t4_status", DMA_STATUS, 32'h4);
      check("t4_q_empty", 32'(exp_q.size()), 32'h0);
      reg_wr(DMA_STATUS, 32'h4);
      rd_chk("t4_stat_clr", DMA_STATUS, 32'h0);

      // Reset asserted mid-READ
      reg_wr(DMA_LEN, 32'd3);
      reg_wr(DMA_CTRL, 32'h03);
      tick();
      check("t5_read_addr", m_addr, 32'h0000_0200);
      rst = 1'b1;
      #1;
      check("t5_busReq", 32'(bus_req), 32'h0);
      check("t5_mWe", 32'(m_we), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      for (int r = 0; r < 5; r++) rd_chk("t5_reg_zero", 3'(r), 32'h0);
      exp_q.delete();

      // Writes and start while busy are ignored; W1C clears done and irq
      reg_wr(DMA_SRC, 32'h0000_0200);
      reg_wr(DMA_DST, 32'h4000_0000);
      reg_wr(DMA_LEN, 32'd3);
      push(32'h4000_0000, 32'h11);
      push(32'h4000_0000, 32'h22);
      push(32'h4000_0000, 32'h33);
      reg_wr(DMA_CTRL, 32'h0B);
      reg_wr(DMA_SRC, 32'h0000_0999);
      reg_wr(DMA_CTRL, 32'h01);
      rd_chk("t6_src_kept", DMA_SRC, 32'h0000_0200);
      rd_chk("t6_ctrl_kept", DMA_CTRL, 32'h0A);
      wait_done(40);
      check("t6_q_empty", 32'(exp_q.size()), 32'h0);
      tick();
      tick();
      check("t6_no_restart", 32'(bus_req), 32'h0);
      check("t6_irq", 32'(irq), 32'h1);
      reg_wr(DMA_STATUS, 32'h2);
      check("t6_irq_clr", 32'(irq), 32'h0);
      rd_chk("t6_stat_clr", DMA_STATUS, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
